// File: rtl/ks_sum_stage.sv
// Final sum/flag stage of the 32-bit Kogge-Stone adder: forms sum, carry-out,
// overflow and zero (optionally saturating) and buffers results in a 2-entry skid.
module ks_sum_stage #(
  parameter bit SAT_EN = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_c0,
  input  logic [31:0] i_pk,
  input  logic [31:0] i_gk,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_sum,
  output logic        o_cout,
  output logic        o_ovf,
  output logic        o_zero
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ready;
  logic [34:0] r_out;
  logic [34:0] r_skid;

  logic [31:0] w_sum_raw;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_ovf;
  logic        w_zero;
  logic [34:0] w_entry;
  logic        w_acc;
  logic        w_emit;
  logic        w_ld_out;
  logic        w_ld_skid;
  logic        w_skid_out;

  // Bit i of the sum takes the carry into bit i, which is the group generate of bit i-1.
  assign w_sum_raw = {i_pk[31:1] ^ i_gk[30:0], i_pk[0] ^ i_c0};
  assign w_cout    = i_gk[31];
  assign w_ovf     = i_gk[30] ^ i_gk[31];

  always_comb begin
    w_sum = w_sum_raw;
    if (SAT_EN && w_ovf) begin
      w_sum = w_cout ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  assign w_zero  = (w_sum == 32'd0);
  assign w_entry = {w_zero, w_ovf, w_cout, w_sum};

  assign w_acc  = i_valid & r_ready;
  assign w_emit = (r_state != S_EMPTY) & i_ready;

  always_comb begin
    w_next     = r_state;
    w_ld_out   = 1'b0;
    w_ld_skid  = 1'b0;
    w_skid_out = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_next   = S_ONE;
          w_ld_out = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_emit) begin
          w_ld_out = 1'b1;
        end else if (w_acc) begin
          w_next    = S_TWO;
          w_ld_skid = 1'b1;
        end else if (w_emit) begin
          w_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_emit) begin
          w_next     = S_ONE;
          w_skid_out = 1'b1;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_EMPTY;
      r_ready <= 1'b0;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      // Ready is registered from the next state so no combinational path reaches o_ready.
      r_ready <= (w_next != S_TWO);
      if (w_ld_out) begin
        r_out <= w_entry;
      end else if (w_skid_out) begin
        r_out <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_entry;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_state != S_EMPTY);
  assign o_sum   = r_out[31:0];
  assign o_cout  = r_out[32];
  assign o_ovf   = r_out[33];
  assign o_zero  = r_out[34];

endmodule

// File: tb/tb_ks_sum_stage.sv
// Bench for ks_sum_stage: wrapping and saturating instances share stimulus and are
// checked every cycle against an arithmetic scoreboard, plus literal directed results.
module tb_ks_sum_stage;

  typedef struct {
    logic [31:0] s0;
    logic [31:0] s1;
    logic        cout;
    logic        ovf;
    logic        z0;
    logic        z1;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic        i_c0 = 1'b0;
  logic [31:0] i_pk = '0;
  logic [31:0] i_gk = '0;

  logic        o_ready0, o_valid0, o_cout0, o_ovf0, o_zero0;
  logic [31:0] o_sum0;
  logic        o_ready1, o_valid1, o_cout1, o_ovf1, o_zero1;
  logic [31:0] o_sum1;

  ks_sum_stage #(.SAT_EN(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready0),
    .i_c0(i_c0), .i_pk(i_pk), .i_gk(i_gk), .o_valid(o_valid0), .i_ready(i_ready),
    .o_sum(o_sum0), .o_cout(o_cout0), .o_ovf(o_ovf0), .o_zero(o_zero0)
  );

  ks_sum_stage #(.SAT_EN(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready1),
    .i_c0(i_c0), .i_pk(i_pk), .i_gk(i_gk), .o_valid(o_valid1), .i_ready(i_ready),
    .o_sum(o_sum1), .o_cout(o_cout1), .o_ovf(o_ovf1), .o_zero(o_zero1)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected result from the operands themselves, not from p/g.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c0);
    exp_t e;
    logic [32:0] full;
    full   = {1'b0, a} + {1'b0, b} + {32'd0, c0};
    e.s0   = full[31:0];
    e.cout = full[32];
    e.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
    e.s1   = e.ovf ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : e.s0;
    e.z0   = (e.s0 == 32'd0);
    e.z1   = (e.s1 == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] gen_gk(input logic [31:0] a, input logic [31:0] b, input logic c0);
    logic [31:0] g;
    logic [63:0] mask, t;
    for (int i = 0; i < 32; i++) begin
      mask = (64'd1 << (i + 1)) - 64'd1;
      t    = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, c0};
      g[i] = t[i+1];
    end
    return g;
  endfunction

  logic [31:0] cur_a = '0, cur_b = '0;
  logic        cur_c0 = 1'b0;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c0);
    cur_a   = a;
    cur_b   = b;
    cur_c0  = c0;
    i_valid = v;
    i_c0    = c0;
    i_pk    = a ^ b;
    i_gk    = gen_gk(a, b, c0);
  endtask

  task automatic idle();
    drive(1'b0, $urandom, $urandom, 1'($urandom_range(1)));
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: queue of beats held by the stage, registered ready flag.
  exp_t m_q[$];
  logic m_rdy = 1'b0;
  logic m_acc_last = 1'b0;
  int   n_acc = 0;
  int   n_emit = 0;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_q.delete();
      m_rdy      = 1'b0;
      m_acc_last = 1'b0;
    end else begin
      logic acc, emit;
      acc  = i_valid && m_rdy;
      emit = (m_q.size() != 0) && i_ready;
      if (emit) begin
        void'(m_q.pop_front());
        n_emit++;
      end
      if (acc) begin
        m_q.push_back(model(cur_a, cur_b, cur_c0));
        n_acc++;
      end
      m_acc_last = acc;
      m_rdy      = (m_q.size() < 2);
    end
  end

  logic        hold_prev = 1'b0;
  logic [31:0] hold_s0, hold_s1;

  always @(negedge i_clk) begin
    if (i_rst) begin
      hold_prev = 1'b0;
    end else begin
      check("valid0", o_valid0, (m_q.size() != 0));
      check("valid1", o_valid1, (m_q.size() != 0));
      check("ready0", o_ready0, m_rdy);
      check("ready1", o_ready1, m_rdy);
      if (m_q.size() != 0) begin
        check("sum0", o_sum0, m_q[0].s0);
        check("sum1", o_sum1, m_q[0].s1);
        check("cout0", o_cout0, m_q[0].cout);
        check("cout1", o_cout1, m_q[0].cout);
        check("ovf0", o_ovf0, m_q[0].ovf);
        check("ovf1", o_ovf1, m_q[0].ovf);
        check("zero0", o_zero0, m_q[0].z0);
        check("zero1", o_zero1, m_q[0].z1);
      end
      if (hold_prev) begin
        check("hold0", o_sum0, hold_s0);
        check("hold1", o_sum1, hold_s1);
      end
      hold_prev = o_valid0 && !i_ready;
      hold_s0   = o_sum0;
      hold_s1   = o_sum1;
    end
  end

  task automatic one_beat(input logic [31:0] a, input logic [31:0] b, input logic c0);
    i_ready = 1'b1;
    drive(1'b1, a, b, c0);
    step();
    idle();
    @(negedge i_clk);
  endtask

  logic [31:0] ba[8], bb[8];
  logic        bc[8];
  int          idx, acc0, emit0;
  exp_t        pin;

  initial begin
    idle();
    #3;
    check("rst_valid", o_valid0, 1'b0);
    check("rst_ready", o_ready0, 1'b0);
    check("rst_sum", o_sum0, 32'd0);
    check("rst_flags", {o_cout0, o_ovf0, o_zero0}, 3'b000);
    #9 i_rst = 1'b0;
    @(negedge i_clk);
    check("ready_rise", o_ready0, 1'b1);

    pin = model(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    check("pin_sum", pin.s0, 32'd0);
    check("pin_gk", gen_gk(32'h0000_0001, 32'hFFFF_FFFF, 1'b0), 32'hFFFF_FFFF);
    pin = model(32'h7FFF_FFFF, 32'h1, 1'b0);
    check("pin_sat", pin.s1, 32'h7FFF_FFFF);

    step();
    one_beat(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    check("t1_sum", o_sum0, 32'h0);
    check("t1_flags", {o_cout0, o_ovf0, o_zero0}, 3'b101);
    step();
    one_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("t2_sum_wrap", o_sum0, 32'h8000_0000);
    check("t2_cout_ovf", {o_cout0, o_ovf0}, 2'b01);
    check("t2_sum_sat", o_sum1, 32'h7FFF_FFFF);
    check("t2_sat_ovf_zero", {o_ovf1, o_zero1}, 2'b10);
    step();
    one_beat(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("t3_sum_sat", o_sum1, 32'h8000_0000);
    check("t3_sat_cout_ovf", {o_cout1, o_ovf1}, 2'b11);
    check("t3_sum_wrap", o_sum0, 32'h7FFF_FFFF);
    step();
    step();

    for (int k = 0; k < 8; k++) begin
      ba[k] = $urandom;
      bb[k] = $urandom;
      bc[k] = 1'($urandom_range(1));
    end
    idx   = 0;
    acc0  = n_acc;
    emit0 = n_emit;
    for (int cyc = 0; cyc < 7; cyc++) begin
      i_ready = (cyc < 3);
      if (idx < 8) drive(1'b1, ba[idx], bb[idx], bc[idx]);
      else idle();
      step();
      if (m_acc_last) idx++;
    end
    @(negedge i_clk);
    check("bp_ready", o_ready0, 1'b0);
    check("bp_buffered", n_acc - n_emit, 2);
    check("bp_accepted", idx, 4);
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && (n_emit - emit0) < 8; cyc++) begin
      if (idx < 8) drive(1'b1, ba[idx], bb[idx], bc[idx]);
      else idle();
      step();
      if (m_acc_last) idx++;
    end
    check("bp_emitted", n_emit - emit0, 8);
    check("bp_acc_total", n_acc - acc0, 8);

    i_ready = 1'b0;
    for (int cyc = 0; cyc < 10 && m_q.size() < 2; cyc++) begin
      drive(1'b1, $urandom, $urandom, 1'b0);
      step();
    end
    idle();
    @(negedge i_clk);
    check("pre_rst_two", o_ready0, 1'b0);
    #1 i_rst = 1'b1;
    #1;
    check("rst_mid_valid", {o_valid0, o_valid1}, 2'b00);
    check("rst_mid_ready", {o_ready0, o_ready1}, 2'b00);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    i_ready = 1'b1;
    step();
    one_beat(32'd2, 32'd3, 1'b0);
    check("post_rst_sum", o_sum0, 32'd5);
    check("post_rst_sum_sat", o_sum1, 32'd5);
    step();

    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7))
        0: a = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = ~a;
        default: ;
      endcase
      i_ready = ($urandom_range(3) != 0);
      drive(1'($urandom_range(1)), a, b, 1'($urandom_range(1)));
      step();
    end
    idle();
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) step();
    @(negedge i_clk);
    check("drained", m_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
